// File: rtl/matrix_host_master.sv
// matrix_host_master: bus initiator for the matrix accelerator slave port.
//
// Per command it loads N operand pairs from an external operand RAM, writes each
// to the accelerator, starts the operation, waits for m_interrupt (bounded by
// TIMEOUT), reads R result registers into a result sink, then clears the
// accelerator.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   start                 one-cycle command pulse, honoured only while idle
//   op_count, res_count   operand pairs / results for the command (clamped to 8)
//   op_addr, op_rdata     operand RAM read port (data one cycle after address)
//   S_sel, S_wr,
//   S_address, S_din      slave bus request, one clock per bus cycle
//   S_dout                slave read data, one cycle after a read cycle
//   m_interrupt           operation-complete level from the accelerator
//   res_we, res_addr,
//   res_data              result sink write port
//   busy, done, err       status: active, end-of-command pulse, sticky timeout

module matrix_host_master #(
    parameter logic [7:0]  ADDR_MULTIPLIER   = 8'h00,
    parameter logic [7:0]  ADDR_MULTIPLICAND = 8'h01,
    parameter logic [7:0]  ADDR_START        = 8'h02,
    parameter logic [7:0]  ADDR_CLEAR        = 8'h03,
    parameter logic [7:0]  ADDR_RESULT_BASE  = 8'h10,
    parameter int unsigned TIMEOUT           = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op_count,
    input  logic [3:0]  res_count,
    output logic [3:0]  op_addr,
    input  logic [31:0] op_rdata,
    output logic        S_sel,
    output logic        S_wr,
    output logic [7:0]  S_address,
    output logic [31:0] S_din,
    input  logic [31:0] S_dout,
    input  logic        m_interrupt,
    output logic        res_we,
    output logic [2:0]  res_addr,
    output logic [31:0] res_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned TmoW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        StIdle,
        StRdMr,
        StWrMr,
        StRdMd,
        StWrMd,
        StStart,
        StWaitIrq,
        StReadReq,
        StReadCap,
        StClear,
        StDone
    } state_e;

    state_e            state_q;
    logic [3:0]        n_q;
    logic [3:0]        r_q;
    logic [3:0]        k_q;
    logic [3:0]        i_q;
    logic [TmoW-1:0]   tmo_q;
    logic [31:0]       din_q;
    // Operand write cycles forward RAM data directly: it only becomes valid in
    // the write cycle itself, so it cannot be registered on entry.
    logic              din_ram_q;

    logic [3:0]        n_clamp;
    logic [3:0]        r_clamp;

    assign n_clamp  = (op_count  > 4'd8) ? 4'd8 : op_count;
    assign r_clamp  = (res_count > 4'd8) ? 4'd8 : res_count;

    assign S_din    = din_ram_q ? op_rdata : din_q;
    // Slave read data is valid exactly in the capture cycle.
    assign res_data = res_we ? S_dout : '0;

    // Outputs for each state are registered on the transition into that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            n_q       <= '0;
            r_q       <= '0;
            k_q       <= '0;
            i_q       <= '0;
            tmo_q     <= '0;
            din_q     <= '0;
            din_ram_q <= 1'b0;
            op_addr   <= '0;
            S_sel     <= 1'b0;
            S_wr      <= 1'b0;
            S_address <= '0;
            res_we    <= 1'b0;
            res_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            S_sel     <= 1'b0;
            S_wr      <= 1'b0;
            S_address <= '0;
            din_q     <= '0;
            din_ram_q <= 1'b0;
            res_we    <= 1'b0;
            done      <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        n_q  <= n_clamp;
                        r_q  <= r_clamp;
                        err  <= 1'b0;
                        k_q  <= '0;
                        busy <= 1'b1;
                        if (n_clamp == 4'd0) begin
                            state_q   <= StStart;
                            S_sel     <= 1'b1;
                            S_wr      <= 1'b1;
                            S_address <= ADDR_START;
                            din_q     <= 32'h1;
                        end else begin
                            state_q <= StRdMr;
                            op_addr <= '0;
                        end
                    end
                end

                StRdMr: begin
                    state_q   <= StWrMr;
                    S_sel     <= 1'b1;
                    S_wr      <= 1'b1;
                    S_address <= ADDR_MULTIPLIER;
                    din_ram_q <= 1'b1;
                end

                StWrMr: begin
                    state_q <= StRdMd;
                    op_addr <= {k_q[2:0], 1'b1};
                end

                StRdMd: begin
                    state_q   <= StWrMd;
                    S_sel     <= 1'b1;
                    S_wr      <= 1'b1;
                    S_address <= ADDR_MULTIPLICAND;
                    din_ram_q <= 1'b1;
                end

                StWrMd: begin
                    k_q <= k_q + 4'd1;
                    if (k_q + 4'd1 == n_q) begin
                        state_q   <= StStart;
                        S_sel     <= 1'b1;
                        S_wr      <= 1'b1;
                        S_address <= ADDR_START;
                        din_q     <= 32'h1;
                    end else begin
                        state_q <= StRdMr;
                        op_addr <= {k_q[2:0] + 3'd1, 1'b0};
                    end
                end

                StStart: begin
                    state_q <= StWaitIrq;
                    tmo_q   <= '0;
                end

                StWaitIrq: begin
                    if (m_interrupt) begin
                        i_q <= '0;
                        if (r_q == 4'd0) begin
                            state_q   <= StClear;
                            S_sel     <= 1'b1;
                            S_wr      <= 1'b1;
                            S_address <= ADDR_CLEAR;
                            din_q     <= 32'h1;
                        end else begin
                            state_q   <= StReadReq;
                            S_sel     <= 1'b1;
                            S_address <= ADDR_RESULT_BASE;
                        end
                    end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                        // Give up on the interrupt: flag it and skip readback.
                        err       <= 1'b1;
                        state_q   <= StClear;
                        S_sel     <= 1'b1;
                        S_wr      <= 1'b1;
                        S_address <= ADDR_CLEAR;
                        din_q     <= 32'h1;
                    end else begin
                        tmo_q <= tmo_q + TmoW'(1);
                    end
                end

                StReadReq: begin
                    state_q  <= StReadCap;
                    res_we   <= 1'b1;
                    res_addr <= i_q[2:0];
                end

                StReadCap: begin
                    i_q <= i_q + 4'd1;
                    if (i_q + 4'd1 == r_q) begin
                        state_q   <= StClear;
                        S_sel     <= 1'b1;
                        S_wr      <= 1'b1;
                        S_address <= ADDR_CLEAR;
                        din_q     <= 32'h1;
                    end else begin
                        state_q   <= StReadReq;
                        S_sel     <= 1'b1;
                        S_address <= ADDR_RESULT_BASE + {4'b0000, i_q + 4'd1};
                    end
                end

                StClear: begin
                    state_q <= StDone;
                    done    <= 1'b1;
                end

                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
